// File: rtl/pipe_pkg.sv
// Shared constants, control-mode encoding and elaboration helpers for the
// pipe_ctrl sequencer and its register scoreboard.
package pipe_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = '0;

    localparam int unsigned F = 0;
    localparam int unsigned D = 1;

    typedef enum logic [1:0] {
        CTL_RUN,
        CTL_STALL,
        CTL_FLUSH
    } ctl_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned p;
        int unsigned r;
        p = 1;
        r = 0;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/writeback/redirect inputs and pipeline state outputs of pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned PC_W   = 64,
    parameter int unsigned REG_AW = 5
);

    logic [1:0]             dec_src_en;
    logic [2*REG_AW-1:0]    dec_src_addr;
    logic [1:0]             dec_dst_en;
    logic [2*REG_AW-1:0]    dec_dst_addr;
    logic [1:0]             wb_dst_en;
    logic [2*REG_AW-1:0]    wb_dst_addr;
    logic                   redirect_en;
    logic [PC_W-1:0]        redirect_pc;
    logic [PC_W-1:0]        pc_f;
    logic [STAGES-1:0]      stage_valid;
    logic [STAGES*PC_W-1:0] stage_pc;
    logic                   stall;
    logic                   flush;
    logic [31:0]            stall_cnt;
    logic [31:0]            flush_cnt;

    modport master (
        output dec_src_en, dec_src_addr, dec_dst_en, dec_dst_addr,
        output wb_dst_en, wb_dst_addr, redirect_en, redirect_pc,
        input  pc_f, stage_valid, stage_pc, stall, flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  dec_src_en, dec_src_addr, dec_dst_en, dec_dst_addr,
        input  wb_dst_en, wb_dst_addr, redirect_en, redirect_pc,
        output pc_f, stage_valid, stage_pc, stall, flush, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-GPR pending-write counters with a two-port busy query that honours the
// optional WB-to-D bypass.
module reg_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned STAGES = 4,
    parameter int unsigned REG_AW = 5,
    parameter bit          FWD_WB = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                inc_en,
    input  logic [1:0]          inc_dst_en,
    input  logic [2*REG_AW-1:0] inc_dst_addr,
    input  logic                dec_en,
    input  logic [1:0]          dec_dst_en,
    input  logic [2*REG_AW-1:0] dec_dst_addr,
    input  logic [1:0]          src_en,
    input  logic [2*REG_AW-1:0] src_addr,
    output logic                busy
);

    localparam int unsigned NREG = 2 ** REG_AW;
    localparam int unsigned CW   = clog2(STAGES);

    logic [CW-1:0]   count [NREG];
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic [1:0]      src_busy;

    // Two ports naming the same register still raise a single flag, so the
    // count moves by at most one per cycle in each direction.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            inc_vec[r] = inc_en &&
                ((inc_dst_en[0] && inc_dst_addr[REG_AW-1:0] == REG_AW'(r)) ||
                 (inc_dst_en[1] && inc_dst_addr[2*REG_AW-1:REG_AW] == REG_AW'(r)));
            dec_vec[r] = dec_en &&
                ((dec_dst_en[0] && dec_dst_addr[REG_AW-1:0] == REG_AW'(r)) ||
                 (dec_dst_en[1] && dec_dst_addr[2*REG_AW-1:REG_AW] == REG_AW'(r)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int unsigned r = 0; r < NREG; r++) count[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) count[r] <= count[r] + CW'(1);
                else if (dec_vec[r] && !inc_vec[r]) count[r] <= count[r] - CW'(1);
            end
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_src
        logic [REG_AW-1:0] addr;
        logic [CW-1:0]     cnt;
        logic              wb_hit;
        logic              bypass;

        assign addr   = src_addr[k*REG_AW +: REG_AW];
        assign cnt    = count[addr];
        assign wb_hit = dec_en &&
            ((dec_dst_en[0] && dec_dst_addr[REG_AW-1:0] == addr) ||
             (dec_dst_en[1] && dec_dst_addr[2*REG_AW-1:REG_AW] == addr));
        // Only the sole outstanding writer can be forwarded, and only from WB.
        assign bypass      = FWD_WB && (cnt == CW'(1)) && wb_hit;
        assign src_busy[k] = src_en[k] && (cnt != '0) && !bypass;
    end

    assign busy = |src_busy;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: fetch PC, per-stage valid/PC chain, hazard stall and
// redirect flush arbitration, plus stall/flush event counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned     STAGES   = 4,
    parameter int unsigned     PC_W     = 64,
    parameter int unsigned     REG_AW   = 5,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
    parameter bit              FWD_WB   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    logic [PC_W-1:0]               pc_q, pc_d;
    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:1][PC_W-1:0]   spc_q, spc_d;
    logic [31:0]                   stall_cnt_q, flush_cnt_q;
    logic                          sb_busy;
    logic                          hazard;
    logic                          flush_w;
    logic                          stall_w;
    logic                          dec_advance;
    ctl_e                          ctl;

    assign flush_w     = bus.redirect_en && valid_q[STAGES-1];
    assign hazard      = valid_q[D] && sb_busy;
    assign stall_w     = hazard && !flush_w;
    assign dec_advance = valid_q[D] && (ctl == CTL_RUN);

    always_comb begin
        ctl = CTL_RUN;
        if (flush_w)     ctl = CTL_FLUSH;
        else if (hazard) ctl = CTL_STALL;
    end

    reg_scoreboard #(
        .STAGES (STAGES),
        .REG_AW (REG_AW),
        .FWD_WB (FWD_WB)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .clear        (flush_w),
        .inc_en       (dec_advance),
        .inc_dst_en   (bus.dec_dst_en),
        .inc_dst_addr (bus.dec_dst_addr),
        .dec_en       (valid_q[STAGES-1]),
        .dec_dst_en   (bus.wb_dst_en),
        .dec_dst_addr (bus.wb_dst_addr),
        .src_en       (bus.dec_src_en),
        .src_addr     (bus.dec_src_addr),
        .busy         (sb_busy)
    );

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        spc_d   = spc_q;
        for (int unsigned i = 2; i < STAGES; i++) spc_d[i] = spc_q[i-1];
        unique case (ctl)
            CTL_FLUSH: begin
                pc_d       = bus.redirect_pc;
                valid_d    = '0;
                valid_d[F] = 1'b1;
            end
            CTL_STALL: begin
                valid_d[2] = 1'b0;
                for (int unsigned i = 3; i < STAGES; i++) valid_d[i] = valid_q[i-1];
            end
            default: begin
                // pc_f only moves past a live fetch, so RESET_PC itself is issued.
                if (valid_q[F]) pc_d = pc_q + PC_W'(INSTR_BYTES);
                spc_d[1]   = pc_q;
                valid_d[F] = 1'b1;
                for (int unsigned i = 1; i < STAGES; i++) valid_d[i] = valid_q[i-1];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            valid_q     <= '0;
            spc_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            spc_q       <= spc_d;
            stall_cnt_q <= stall_cnt_q + 32'(stall_w);
            flush_cnt_q <= flush_cnt_q + 32'(flush_w);
        end
    end

    assign bus.pc_f        = pc_q;
    assign bus.stage_valid = valid_q;
    assign bus.stage_pc    = {spc_q, pc_q};
    assign bus.stall       = stall_w;
    assign bus.flush       = flush_w;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (WB bypass on/off) run a fixed
// PC-addressed program; per-cycle expectations are queued and checked at negedge.
module tb_pipe_ctrl;

    localparam int unsigned ST = 4;
    localparam int unsigned PW = 64;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    pipe_ctrl_if #(.STAGES(ST), .PC_W(PW), .REG_AW(AW)) bus_a ();
    pipe_ctrl_if #(.STAGES(ST), .PC_W(PW), .REG_AW(AW)) bus_b ();

    pipe_ctrl #(.STAGES(ST), .PC_W(PW), .REG_AW(AW), .RESET_PC(64'h0), .FWD_WB(1'b1))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    pipe_ctrl #(.STAGES(ST), .PC_W(PW), .REG_AW(AW), .RESET_PC(64'h0), .FWD_WB(1'b0))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    typedef struct packed {
        logic [1:0]      se;
        logic [2*AW-1:0] sa;
        logic [1:0]      de;
        logic [2*AW-1:0] da;
    } instr_t;

    // Program image keyed by PC; everything not listed is a nop.
    function automatic instr_t prog(input logic [PW-1:0] pc);
        instr_t r;
        r = '0;
        case (pc)
            64'h008: begin r.de = 2'b11; r.da = {5'd5, 5'd5}; end
            64'h00C: begin r.se = 2'b10; r.sa = {5'd5, 5'd0}; end
            64'h014: begin r.de = 2'b10; r.da = {5'd5, 5'd0}; end
            64'h104: begin r.se = 2'b01; r.sa = {5'd0, 5'd5}; end
            64'h108: begin r.de = 2'b01; r.da = {5'd0, 5'd6}; end
            64'h10C: begin r.se = 2'b11; r.sa = {5'd3, 5'd6}; end
            default: r = '0;
        endcase
        return r;
    endfunction

    instr_t ia_d, ia_w, ib_d, ib_w;
    always_comb begin
        ia_d = prog(bus_a.stage_pc[1*PW +: PW]);
        ia_w = prog(bus_a.stage_pc[3*PW +: PW]);
        ib_d = prog(bus_b.stage_pc[1*PW +: PW]);
        ib_w = prog(bus_b.stage_pc[3*PW +: PW]);
    end

    assign bus_a.dec_src_en   = ia_d.se;
    assign bus_a.dec_src_addr = ia_d.sa;
    assign bus_a.dec_dst_en   = ia_d.de;
    assign bus_a.dec_dst_addr = ia_d.da;
    assign bus_a.wb_dst_en    = ia_w.de;
    assign bus_a.wb_dst_addr  = ia_w.da;
    assign bus_b.dec_src_en   = ib_d.se;
    assign bus_b.dec_src_addr = ib_d.sa;
    assign bus_b.dec_dst_en   = ib_d.de;
    assign bus_b.dec_dst_addr = ib_d.da;
    assign bus_b.wb_dst_en    = ib_w.de;
    assign bus_b.wb_dst_addr  = ib_w.da;

    typedef struct {
        logic [PW-1:0] pc;
        logic [3:0]    v;
        logic          st;
        logic          fl;
        logic [31:0]   sc;
        logic [31:0]   fc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_na = 0;
    int   cyc_nb = 0;

    task automatic cyc_a(input logic r, input logic re, input logic [PW-1:0] rpc,
                         input logic [PW-1:0] pc, input logic [3:0] v, input logic st,
                         input logic fl, input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_a             = r;
        bus_a.redirect_en = re;
        bus_a.redirect_pc = rpc;
        e.pc = pc; e.v = v; e.st = st; e.fl = fl; e.sc = sc; e.fc = fc;
        qa.push_back(e);
    endtask

    task automatic cyc_b(input logic r, input logic [PW-1:0] pc, input logic [3:0] v,
                         input logic st, input logic [31:0] sc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_b             = r;
        bus_b.redirect_en = 1'b0;
        bus_b.redirect_pc = '0;
        e.pc = pc; e.v = v; e.st = st; e.fl = 1'b0; e.sc = sc; e.fc = '0;
        qb.push_back(e);
    endtask

    task automatic chk(input string n, input int c, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: actual=%0h required=%0h", n, c, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a.pc_f",        cyc_na, 64'(bus_a.pc_f),        64'(e.pc));
            chk("a.stage_valid", cyc_na, 64'(bus_a.stage_valid), 64'(e.v));
            chk("a.stall",       cyc_na, 64'(bus_a.stall),       64'(e.st));
            chk("a.flush",       cyc_na, 64'(bus_a.flush),       64'(e.fl));
            chk("a.stall_cnt",   cyc_na, 64'(bus_a.stall_cnt),   64'(e.sc));
            chk("a.flush_cnt",   cyc_na, 64'(bus_a.flush_cnt),   64'(e.fc));
            cyc_na++;
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b.pc_f",        cyc_nb, 64'(bus_b.pc_f),        64'(e.pc));
            chk("b.stage_valid", cyc_nb, 64'(bus_b.stage_valid), 64'(e.v));
            chk("b.stall",       cyc_nb, 64'(bus_b.stall),       64'(e.st));
            chk("b.flush",       cyc_nb, 64'(bus_b.flush),       64'(e.fl));
            chk("b.stall_cnt",   cyc_nb, 64'(bus_b.stall_cnt),   64'(e.sc));
            chk("b.flush_cnt",   cyc_nb, 64'(bus_b.flush_cnt),   64'(e.fc));
            cyc_nb++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus_a.redirect_en = 1'b0;
        bus_a.redirect_pc = '0;
        bus_b.redirect_en = 1'b0;
        bus_b.redirect_pc = '0;
        fork
            begin
                //     rst  ren   rpc       pc_f      valid  st  fl  scnt fcnt
                cyc_a(1'b1, 1'b0, 64'h0,   64'h000, 4'h0, 0, 0, 0, 0);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h000, 4'h0, 0, 0, 0, 0);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h000, 4'h1, 0, 0, 0, 0);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h004, 4'h3, 0, 0, 0, 0);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h008, 4'h7, 0, 0, 0, 0);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h00C, 4'hF, 0, 0, 0, 0);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h010, 4'hF, 1, 0, 0, 0);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h010, 4'hB, 0, 0, 1, 0);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h014, 4'h7, 0, 0, 1, 0);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h018, 4'hF, 0, 0, 1, 0);
                cyc_a(1'b0, 1'b1, 64'h100, 64'h01C, 4'hF, 0, 1, 1, 0);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h100, 4'h1, 0, 0, 1, 1);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h104, 4'h3, 0, 0, 1, 1);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h108, 4'h7, 0, 0, 1, 1);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h10C, 4'hF, 0, 0, 1, 1);
                cyc_a(1'b0, 1'b1, 64'h200, 64'h110, 4'hF, 0, 1, 1, 1);
                cyc_a(1'b0, 1'b1, 64'h300, 64'h200, 4'h1, 0, 0, 1, 2);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h204, 4'h3, 0, 0, 1, 2);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h208, 4'h7, 0, 0, 1, 2);
                cyc_a(1'b1, 1'b1, 64'h400, 64'h20C, 4'hF, 0, 1, 1, 2);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h000, 4'h0, 0, 0, 0, 0);
                cyc_a(1'b0, 1'b0, 64'h0,   64'h000, 4'h1, 0, 0, 0, 0);
            end
            begin
                //     rst   pc_f     valid  st  scnt
                cyc_b(1'b1, 64'h000, 4'h0, 0, 0);
                cyc_b(1'b0, 64'h000, 4'h0, 0, 0);
                cyc_b(1'b0, 64'h000, 4'h1, 0, 0);
                cyc_b(1'b0, 64'h004, 4'h3, 0, 0);
                cyc_b(1'b0, 64'h008, 4'h7, 0, 0);
                cyc_b(1'b0, 64'h00C, 4'hF, 0, 0);
                cyc_b(1'b0, 64'h010, 4'hF, 1, 0);
                cyc_b(1'b0, 64'h010, 4'hB, 1, 1);
                cyc_b(1'b0, 64'h010, 4'h3, 0, 2);
                cyc_b(1'b0, 64'h014, 4'h7, 0, 2);
                cyc_b(1'b0, 64'h018, 4'hF, 0, 2);
            end
        join
        @(negedge clk);
        #1;
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d/%0d entries left required=0/0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline sequencer for the PowerPC core. It generates the fetch PC and tracks a valid bit and PC for every stage. It flushes younger stages when the final stage redirects. Unlike the fixed F/D/E/WB forwarding-only pipeline, it keeps a per-register pending-write scoreboard and stalls decode on read-after-write hazards that bypassing cannot cover.

## Interface
Parameters:
- STAGES, 4, stage count; stage 0 = F, 1 = D, STAGES-1 = WB; minimum 3
- PC_W, 64, PC width
- REG_AW, 5, GPR address width (2**REG_AW registers)
- RESET_PC, 0, fetch PC after reset
- FWD_WB, 1, 1 = a WB-stage producer is bypassed to D; 0 = D waits until the producer retires

Ports (clock `clk`; reset `rst`, synchronous, active-high):
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- dec_src_en  in  2  source operand enables, instruction in stage 1
- dec_src_addr  in  2*REG_AW  source registers; [REG_AW-1:0] = src0
- dec_dst_en  in  2  destination enables (rt/ra-update ports)
- dec_dst_addr  in  2*REG_AW  destination registers
- wb_dst_en  in  2  destination enables of the instruction in stage STAGES-1
- wb_dst_addr  in  2*REG_AW  its destination registers
- redirect_en  in  1  final-stage taken branch
- redirect_pc  in  PC_W  branch target
- pc_f  out  PC_W  fetch address (stage 0 PC)
- stage_valid  out  STAGES  per-stage valid; bit i = stage i
- stage_pc  out  STAGES*PC_W  per-stage PC; slice i = stage i
- stall  out  1  decode hazard stall (combinational)
- flush  out  1  redirect accepted this cycle (combinational)
- stall_cnt  out  32  cycles with stall=1, wraps
- flush_cnt  out  32  accepted redirects, wraps

## Operation
- Redirect is accepted when redirect_en && stage_valid[STAGES-1]. Otherwise redirect_en is ignored.
- Hazard: stage_valid[1] && some enabled source has count[src] > 0, excluding the bypass case.
  - Bypass case: FWD_WB=1, count[src] == 1, and the stage STAGES-1 instruction is valid with a matching enabled destination.
- stall = hazard && !flush. A redirect always wins over a stall.
- Normal cycle:
  - pc_f <= pc_f + 4 (PC_W wrap).
  - Every stage i>0 takes the valid bit and PC of stage i-1.
  - stage_valid[0] <= 1.
- Stall cycle:
  - pc_f, stage 0 and stage 1 hold.
  - Stage 2 receives valid=0.
  - Stages >2 advance normally.
- Flush cycle:
  - pc_f <= redirect_pc.
  - stage_valid[STAGES-1:1] <= 0; stage_valid[0] <= 1.
- Scoreboard: one counter per register, width clog2(STAGES).
  - Increment: for each enabled dec_dst when stage 1 advances (valid && !stall && !flush). If both destinations name the same register, count it once.
  - Decrement: for each enabled wb_dst when stage_valid[STAGES-1]. Same dedup rule.
  - Increment and decrement of the same register in one cycle: net zero.
  - Flush clears all counters. Every older instruction has retired, and the redirecting one retires this cycle.
- Counters never exceed STAGES-2. Over- or underflow is a verification error, not a handled case.

## Timing
- Reset values:
  - pc_f = RESET_PC; stage_pc = 0.
  - stage_valid = 0; all counters = 0.
  - stall_cnt = flush_cnt = 0.
  - stall/flush = 0 (combinational; stage_valid=0).
- The first cycle after rst falls: stage_valid = 0001.
- Stall-free latency: fetch at cycle t reaches stage STAGES-1 at t+STAGES-1.
- Hazard stall length for a producer immediately ahead in the pipe: STAGES-3 cycles with FWD_WB=1, STAGES-2 cycles with FWD_WB=0.
- Flush penalty: STAGES-1 bubbles. The target is in stage 0 the cycle after the redirect.
- rst mid-operation overrides everything, including a redirect in the same cycle.

## Structure
- Package pipe_pkg holds:
  - INSTR_BYTES = 4
  - the default RESET_PC
  - a clog2 function
  - stage index constants F=0, D=1
- Sub-module reg_scoreboard holds the counter array, increment/decrement/clear logic and the busy/bypass query for two source ports.
- The pipe_ctrl top holds the PC, valid/PC shift chain, control arbitration and perf counters.

## Test plan
All scenarios use STAGES=4, RESET_PC=0 unless noted.
- Reset release: pc_f steps 0, 4, 8, 0xC; stage_valid steps 0001, 0011, 0111, 1111; stall_cnt=0.
- FWD_WB=1: A writes r5, next B reads r5 -> stall=1 for exactly 1 cycle; B enters stage 2 with A in WB; stall_cnt=1.
- FWD_WB=0, same sequence -> 2 stall cycles; stall_cnt=2; count[5] returns to 0 after A retires.
- Redirect with stage 3 valid, redirect_pc=0x100 -> next cycle pc_f=0x100, stage_valid=0001, flush_cnt=1. A pending r5 counter clears, so a later reader of r5 does not stall.
- Redirect and hazard in the same cycle -> flush=1, stall=0, stall_cnt unchanged, pc_f=target.
- redirect_en=1 while stage_valid[3]=0 -> ignored; pc_f increments by 4; flush_cnt unchanged.
